// File: rtl/jpeg_dq_pkg.sv
// Dequantizer shared types: FSM states, zigzag order, saturation.
// ZIGZAG_LUT maps beat index to natural index (row*8 + col).
package jpeg_dq_pkg;

    typedef enum logic [1:0] {
        FILL,
        DRAIN,
        HOLD
    } dq_state_e;

    localparam logic [5:0] ZIGZAG_LUT [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // Clamp p into the signed range of a w-bit value.
    function automatic logic signed [31:0] saturate(
        input logic signed [31:0] p,
        input int w
    );
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (p > hi) return hi;
        if (p < lo) return lo;
        return p;
    endfunction

endpackage

// File: rtl/jpeg_q_pkg.sv
// Quantizer constants shared by the luminance quantizer and dequantizer.
// Q_MATRIX is the standard JPEG luminance table, [row][col].
package jpeg_q_pkg;

    localparam logic [7:0] Q_MATRIX [8][8] = '{
        '{8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61},
        '{8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55},
        '{8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56},
        '{8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62},
        '{8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77},
        '{8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92},
        '{8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101},
        '{8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99}
    };

endpackage

// File: rtl/y_dequantizer_if.sv
// Coefficient stream in, parallel 8x8 block out.
// slave: the dequantizer; master: producer/consumer side.
interface y_dequantizer_if #(
    parameter int IN_W  = 11,
    parameter int OUT_W = 12
);
    logic                                 in_valid;
    logic                                 in_ready;
    logic signed [IN_W-1:0]               in_coef;
    logic                                 in_last;
    logic                                 out_valid;
    logic                                 out_ready;
    logic signed [0:7][0:7][OUT_W-1:0]    out_block;
    logic                                 out_err;

    modport master (
        output in_valid, in_coef, in_last, out_ready,
        input  in_ready, out_valid, out_block, out_err
    );

    modport slave (
        input  in_valid, in_coef, in_last, out_ready,
        output in_ready, out_valid, out_block, out_err
    );
endinterface

// File: rtl/dq_mul_sat.sv
// Two-stage coefficient * Q multiply with output saturation.
// Position tag and valid travel alongside the data.
module dq_mul_sat
    import jpeg_dq_pkg::*;
#(
    parameter int IN_W  = 11,
    parameter int OUT_W = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  in_coef,
    input  logic [7:0]              in_q,
    input  logic [5:0]              in_pos,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] out_val,
    output logic [5:0]              out_pos
);
    logic                   v1;
    logic signed [IN_W-1:0] c1;
    logic [7:0]             q1;
    logic [5:0]             p1;
    logic signed [31:0]     prod;

    assign prod = 32'(c1) * $signed(32'(q1));

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            c1        <= '0;
            q1        <= '0;
            p1        <= '0;
            out_valid <= 1'b0;
            out_val   <= '0;
            out_pos   <= '0;
        end else begin
            v1        <= in_valid;
            out_valid <= v1;
            if (in_valid) begin
                c1 <= in_coef;
                q1 <= in_q;
                p1 <= in_pos;
            end
            if (v1) begin
                out_val <= OUT_W'(saturate(prod, OUT_W));
                out_pos <= p1;
            end
        end
    end
endmodule

// File: rtl/y_dequantizer.sv
// Luminance dequantizer: coefficient stream -> 8x8 block for the IDCT.
// DEQ_ZIGZAG_EN selects zigzag beat order; raster order otherwise.
module y_dequantizer
    import jpeg_dq_pkg::*;
    import jpeg_q_pkg::*;
#(
    parameter int IN_W  = 11,
    parameter int OUT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    y_dequantizer_if.slave   bus
);
    dq_state_e                         state;
    logic [5:0]                        cnt;
    logic                              drain_cnt;
    logic signed [0:7][0:7][OUT_W-1:0] buf_q;
    logic                              err_q;
    logic                              ov_q;

    logic                    acc;
    logic                    end_beat;
    logic [5:0]              pos;
    logic [7:0]              q;
    logic                    wr_en;
    logic signed [OUT_W-1:0] wr_val;
    logic [5:0]              wr_pos;

    assign bus.in_ready  = (state == FILL) && !rst;
    assign bus.out_valid = ov_q;
    assign bus.out_err   = err_q;
    assign bus.out_block = buf_q;

    assign acc      = bus.in_valid && bus.in_ready;
    assign end_beat = bus.in_last || (cnt == 6'd63);

`ifdef DEQ_ZIGZAG_EN
    assign pos = ZIGZAG_LUT[cnt];
`else
    assign pos = cnt;
`endif

    assign q = Q_MATRIX[pos[5:3]][pos[2:0]];

    dq_mul_sat #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (acc),
        .in_coef   (bus.in_coef),
        .in_q      (q),
        .in_pos    (pos),
        .out_valid (wr_en),
        .out_val   (wr_val),
        .out_pos   (wr_pos)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            cnt       <= '0;
            drain_cnt <= 1'b0;
            buf_q     <= '0;
            err_q     <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            if (wr_en)
                buf_q[wr_pos[5:3]][wr_pos[2:0]] <= wr_val;
            unique case (state)
                FILL: begin
                    if (acc) begin
                        cnt <= cnt + 6'd1;
                        if (end_beat) begin
                            state     <= DRAIN;
                            cnt       <= '0;
                            drain_cnt <= 1'b0;
                            err_q     <= !((cnt == 6'd63) && bus.in_last);
                        end
                    end
                end
                // Two cycles let the last product reach the buffer.
                DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt) begin
                        state <= HOLD;
                        ov_q  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state <= FILL;
                        ov_q  <= 1'b0;
                        err_q <= 1'b0;
                        buf_q <= '0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: doc/y_dequantizer.md
Name: y_dequantizer

Overview:
- Inverse of the luminance quantizer, used on the decode/verification path.
- Accepts a stream of quantized Y coefficients, one per beat, with valid/ready handshake, then multiplies each by its Q_MATRIX entry and saturates it.
- Assembles the results into an 8x8 block buffer and presents the whole block in parallel to the IDCT stage with its own valid/ready handshake.

Parameters:
- IN_W, 11, signed width of a quantized input coefficient.
- OUT_W, 12, signed width of a reconstructed DCT coefficient.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input coefficient valid.
- in_ready  out  1  block accepts a coefficient this cycle.
- in_coef  in  IN_W signed  quantized coefficient.
- in_last  in  1  marks the final coefficient of a block.
- out_valid  out  1  out_block/out_err hold a complete block.
- out_ready  in  1  consumer accepts the block.
- out_block  out  [0:7][0:7] x OUT_W signed  dequantized block, [row][col].
- out_err  out  1  block framing error, qualified by out_valid.

Behaviour:
- Reset (rst=1 at a clk edge): state FILL, beat count 0, pipeline valids 0, out_valid=0, out_err=0, out_block all 0, in_ready=0 while rst is high.
- Reset mid-block discards partial data and pipeline contents with no output.
- Beat: a coefficient is accepted on an edge where in_valid && in_ready. Beat index k runs 0..63. The natural position (r,c) of beat k is ZIGZAG_LUT[k] (see Optional Feature).
- Arithmetic:
  - Product = in_coef * Q_MATRIX[r][c]; Q_MATRIX entries are 8-bit unsigned; the product is 19-bit signed.
  - The product saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1], i.e. -2048..2047 at the default width. No rounding.
- Pipeline:
  - Stage 1 registers the coefficient and position on the acceptance edge.
  - Stage 2 registers the saturated product.
  - The buffer write happens on the following edge.
- Three-state machine:
  - FILL: in_ready=1. Buffer is zero-cleared on entry. Transition to DRAIN on the acceptance edge of beat 63 or of any beat with in_last=1.
  - DRAIN: in_ready=0. Holds for exactly 2 cycles while the pipeline flushes, then goes to HOLD. Leaving DRAIN completes the final buffer write.
  - HOLD: out_valid=1; out_block and out_err are stable. On out_valid && out_ready, go to FILL with out_valid=0 next cycle. out_ready is ignored outside HOLD.
- Latency: out_valid is visible 2 cycles after the edge that accepts the last beat. Minimum block period is 64 + 2 + 1 = 67 cycles.
- Framing errors:
  - in_last on beat k<63: block ends early, positions of beats k+1..63 stay 0, out_err=1.
  - Beat 63 without in_last: block ends, out_err=1.
  - in_last on beat 63: out_err=0.
- in_valid low in FILL: no state change, count holds; bubbles are allowed anywhere in a block.

Optional Feature:
- Macro DEQ_ZIGZAG_EN.
- Defined: beat k maps to (r,c) = ZIGZAG_LUT[k] (standard JPEG zigzag).
- Undefined: raster order, r = k[5:3], c = k[2:0]; the LUT is not instantiated.
- All other behaviour is identical.

Decomposition:
- Shared package jpeg_dq_pkg:
  - ZIGZAG_LUT (64 entries of 6-bit natural index).
  - OUT_W-parametric saturate function.
  - state enum {FILL, DRAIN, HOLD}.
- Q_MATRIX comes from the existing quantizer constants header; it is not duplicated.
- One sub-module, dq_mul_sat: 2-stage pipelined multiply + saturate with valid passthrough. The FSM, counter and buffer stay in the top module.

Test Plan (Q_MATRIX = standard JPEG luminance: [0][0]=16, [0][1]=11, [7][7]=99; DEQ_ZIGZAG_EN defined):
- Full block, beat0=5, beat1=-3, beat63=2 with in_last, rest 0 -> out_block[0][0]=80, [0][1]=-33, [7][7]=198, out_err=0, out_valid 2 cycles after beat-63 edge.
- Saturation: beat63=1023, then a second block with beat63=-1024 -> [7][7]=2047, then -2048.
- Backpressure: out_ready=0 for 10 cycles in HOLD -> out_valid stays 1, out_block stable, in_ready=0; block accepted on first out_ready=1, in_ready=1 the next cycle.
- Early last: in_last on beat 10 -> out_err=1, entries of beats 11..63 are 0. Next full block has out_err=0 and no stale data.
- Reset mid-block: rst after 30 beats -> out_valid=0, in_ready=1 the cycle after rst drops; the next 64-beat block reconstructs exactly.
- Bubbles: in_valid toggled randomly 50% over one block -> result identical to the back-to-back case.
